// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin sharing of one 2-stage multiply-add unit
// (result = A*B + C) among NREQ requesters. Results come back in issue order
// and carry the requester id. A flush/halt FSM lets upstream control quiesce
// the unit.
//
// Optional build macro MAC_SHARE_ARBITER_STATS_EN adds stat_issued, a
// saturating 16-bit count of issued operations.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | grants allowed; flush blocks the grant this cycle, goes to DRAIN
// DRAIN | no grants; waits until every in-flight op has been returned
// HALT  | halted=1, no grants; returns to RUN once flush is low
module mac_share_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int LAT   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*WIDTH-1:0] req_c,
   output logic [NREQ-1:0]       req_ready,
   output logic [WIDTH-1:0]      mac_a,
   output logic [WIDTH-1:0]      mac_b,
   output logic [WIDTH-1:0]      mac_c,
   input  logic [2*WIDTH-1:0]    mac_result,
   output logic                  rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [2*WIDTH-1:0]    rsp_data,
   input  logic                  flush,
`ifdef MAC_SHARE_ARBITER_STATS_EN
   output logic [15:0]           stat_issued,
`endif
   output logic                  halted
);

   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   gnt_idx;
   logic             found;
   logic             grant_en;
   logic             fire;
   logic [LAT-1:0]   tag_v;
   logic [IDW-1:0]   tag_id [LAT];

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   // FSM next state, grant enable and halted flag; tag_v covers the pending capture
   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      halted    = 1'b0;
      case (state)
         ST_RUN: begin
            if (flush) state_nxt = ST_DRAIN;
            else       grant_en  = 1'b1;
         end
         ST_DRAIN: begin
            if (tag_v == '0) state_nxt = ST_HALT;
         end
         ST_HALT: begin
            halted = 1'b1;
            if (!flush) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // Round-robin search starting at rr_ptr, wrapping modulo NREQ
   always_comb begin
      int idx;
      idx     = 0;
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = IDW'(idx);
         end
      end
   end

   assign fire = found & grant_en;

   // Grant vector and operand mux; operands are forced to zero when idle
   always_comb begin
      req_ready = '0;
      mac_a     = '0;
      mac_b     = '0;
      mac_c     = '0;
      if (fire) begin
         req_ready[gnt_idx] = 1'b1;
         mac_a = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
         mac_b = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
         mac_c = req_c[int'(gnt_idx)*WIDTH +: WIDTH];
      end
   end

   // Pointer advances past the winner only when an op actually issues
   always_ff @(posedge clk) begin
      if (reset)
         rr_ptr <= '0;
      else if (fire)
         rr_ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
   end

   // Tag pipeline mirrors the unit latency so each result finds its id
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_v <= '0;
         for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
      end else begin
         tag_v[0]  <= fire;
         tag_id[0] <= gnt_idx;
         for (int i = 1; i < LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

   // Capture the unit output when the last tag stage is valid
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= tag_v[LAT-1];
         if (tag_v[LAT-1]) begin
            rsp_id   <= tag_id[LAT-1];
            rsp_data <= mac_result;
         end
      end
   end

`ifdef MAC_SHARE_ARBITER_STATS_EN
   // Saturating issue counter; survives flush, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset)
         stat_issued <= '0;
      else if (fire && stat_issued != 16'hFFFF)
         stat_issued <= stat_issued + 16'd1;
   end
`endif

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed testbench for mac_share_arbiter (WIDTH=8, NREQ=4, LAT=2) with a
// behavioural 2-stage multiply-add unit. Inputs are driven 1 ns after the
// rising edge, outputs are sampled on the falling edge.
module tb_mac_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_a, req_b, req_c;
   logic [3:0]  req_ready;
   logic [7:0]  mac_a, mac_b, mac_c;
   logic [15:0] mac_result = '0;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;
   logic        flush;
   logic        halted;
`ifdef MAC_SHARE_ARBITER_STATS_EN
   logic [15:0] stat_issued;
`endif

   int nvec = 0;
   int nerr = 0;

   logic [7:0] m_a = '0, m_b = '0, m_c = '0;

   always #5 clk = ~clk;

   // Behavioural multiply-add: registered inputs, registered result
   always @(posedge clk) begin
      m_a <= mac_a;
      m_b <= mac_b;
      m_c <= mac_c;
      mac_result <= 16'(m_a) * 16'(m_b) + 16'(m_c);
   end

   mac_share_arbiter #(.WIDTH(8), .NREQ(4), .LAT(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .req_ready(req_ready),
      .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_result(mac_result),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .flush(flush),
`ifdef MAC_SHARE_ARBITER_STATS_EN
      .stat_issued(stat_issued),
`endif
      .halted(halted)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      req_a[i*8 +: 8] = a;
      req_b[i*8 +: 8] = b;
      req_c[i*8 +: 8] = c;
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; req_valid = '0;
      req_a = '0; req_b = '0; req_c = '0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
      nvec++; if (rsp_id !== 2'd0) begin nerr++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
      nvec++; if (rsp_data !== 16'd0) begin nerr++; $display("FAIL reset_rsp_data got %0d want 0", rsp_data); end
      nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted got %0b want 0", halted); end
      nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready got %b want 0000", req_ready); end
      nvec++; if (mac_a !== 8'd0) begin nerr++; $display("FAIL reset_mac_a got %0d want 0", mac_a); end
`ifdef MAC_SHARE_ARBITER_STATS_EN
      nvec++; if (stat_issued !== 16'd0) begin nerr++; $display("FAIL reset_stat got %0d want 0", stat_issued); end
`endif
      next_cycle();
   endtask

   task automatic test_single_op();
      do_reset();
      for (int n = 0; n <= 4; n++) begin
         req_valid = (n == 0) ? 4'b0010 : 4'b0000;
         if (n == 0) set_op(1, 8'd3, 8'd5, 8'd7);
         @(negedge clk);
         if (n == 0) begin
            nvec++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL single_ready got %b want 0010", req_ready); end
            nvec++; if ({mac_a, mac_b, mac_c} !== {8'd3, 8'd5, 8'd7}) begin nerr++; $display("FAIL single_operands got %0d/%0d/%0d want 3/5/7", mac_a, mac_b, mac_c); end
         end
         if (n == 3) begin
            nvec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'd22) begin
               nerr++; $display("FAIL single_rsp got v=%0b id=%0d d=%0d want v=1 id=1 d=22", rsp_valid, rsp_id, rsp_data); end
         end else begin
            nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL single_rsp_idle cycle %0d got %0b want 0", n, rsp_valid); end
         end
         next_cycle();
      end
   endtask

   task automatic test_contention();
      logic [1:0] eid;
      do_reset();
      for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd2, 8'(i));
      for (int n = 0; n <= 15; n++) begin
         req_valid = (n < 12) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         if (n < 12) begin
            nvec++; if (req_ready !== (4'b0001 << (n % 4))) begin
               nerr++; $display("FAIL contention_ready cycle %0d got %b want %b", n, req_ready, 4'b0001 << (n % 4)); end
         end
         if (n >= 3 && n < 15) begin
            eid = 2'((n - 3) % 4);
            nvec++; if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_data !== 16'(3 * int'(eid) + 2)) begin
               nerr++; $display("FAIL contention_rsp cycle %0d got v=%0b id=%0d d=%0d want v=1 id=%0d d=%0d",
                                n, rsp_valid, rsp_id, rsp_data, eid, 3 * int'(eid) + 2); end
         end else begin
            nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL contention_rsp_idle cycle %0d got %0b want 0", n, rsp_valid); end
         end
         next_cycle();
      end
   endtask

   task automatic test_max_values();
      do_reset();
      for (int n = 0; n <= 4; n++) begin
         req_valid = (n < 2) ? 4'b0001 : 4'b0000;
         if (n == 0) set_op(0, 8'd255, 8'd255, 8'd255);
         if (n == 1) set_op(0, 8'd0, 8'd255, 8'd0);
         @(negedge clk);
         if (n < 2) begin
            nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL max_ready cycle %0d got %b want 0001", n, req_ready); end
         end
         if (n == 3) begin
            nvec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd65280) begin
               nerr++; $display("FAIL max_rsp got v=%0b id=%0d d=%0d want v=1 id=0 d=65280", rsp_valid, rsp_id, rsp_data); end
         end
         if (n == 4) begin
            nvec++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd0) begin
               nerr++; $display("FAIL zero_rsp got v=%0b d=%0d want v=1 d=0", rsp_valid, rsp_data); end
         end
         next_cycle();
      end
   endtask

   task automatic test_single_hold();
      do_reset();
      set_op(3, 8'd1, 8'd1, 8'd0);
      for (int n = 0; n < 6; n++) begin
         req_valid = 4'b1000;
         @(negedge clk);
         nvec++; if (req_ready !== 4'b1000) begin nerr++; $display("FAIL hold_ready cycle %0d got %b want 1000", n, req_ready); end
         next_cycle();
      end
      // After granting 3 the pointer wraps to 0, so requester 0 wins over 1
      req_valid = 4'b0011;
      @(negedge clk);
      nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL wrap_ready got %b want 0001", req_ready); end
      next_cycle();
      req_valid = '0;
      repeat (4) next_cycle();
   endtask

   task automatic test_flush_inflight();
      logic [3:0] exp_rdy;
      logic       exp_halt;
      do_reset();
      for (int n = 0; n <= 8; n++) begin
         flush     = (n >= 2 && n < 7);
         req_valid = 4'b0001;
         set_op(0, 8'(n + 2), 8'd3, 8'd1);
         @(negedge clk);
         exp_rdy  = (n < 2 || n == 8) ? 4'b0001 : 4'b0000;
         exp_halt = (n >= 5 && n <= 7);
         nvec++; if (req_ready !== exp_rdy) begin nerr++; $display("FAIL flush_ready cycle %0d got %b want %b", n, req_ready, exp_rdy); end
         nvec++; if (halted !== exp_halt) begin nerr++; $display("FAIL flush_halted cycle %0d got %0b want %0b", n, halted, exp_halt); end
         if (n == 2) begin
            nvec++; if (mac_a !== 8'd0) begin nerr++; $display("FAIL flush_mac_a got %0d want 0", mac_a); end
         end
         if (n == 3) begin
            nvec++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd7) begin nerr++; $display("FAIL flush_rsp0 got v=%0b d=%0d want v=1 d=7", rsp_valid, rsp_data); end
         end else if (n == 4) begin
            nvec++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd10) begin nerr++; $display("FAIL flush_rsp1 got v=%0b d=%0d want v=1 d=10", rsp_valid, rsp_data); end
         end else begin
            nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL flush_rsp_idle cycle %0d got %0b want 0", n, rsp_valid); end
         end
         next_cycle();
      end
      req_valid = '0;
      repeat (4) next_cycle();
   endtask

   task automatic test_flush_pulse();
      do_reset();
      for (int n = 0; n <= 3; n++) begin
         flush     = (n == 0);
         req_valid = 4'b0100;
         @(negedge clk);
         nvec++; if (req_ready !== ((n == 3) ? 4'b0100 : 4'b0000)) begin
            nerr++; $display("FAIL pulse_ready cycle %0d got %b want %b", n, req_ready, (n == 3) ? 4'b0100 : 4'b0000); end
         nvec++; if (halted !== (n == 2)) begin nerr++; $display("FAIL pulse_halted cycle %0d got %0b want %0b", n, halted, n == 2); end
         next_cycle();
      end
      req_valid = '0;
      repeat (4) next_cycle();
   endtask

   task automatic test_reset_mid_flight();
      do_reset();
      set_op(2, 8'd9, 8'd9, 8'd9);
      set_op(0, 8'd2, 8'd2, 8'd2);
      for (int n = 0; n <= 6; n++) begin
         reset     = (n == 1);
         req_valid = (n == 0) ? 4'b0100 : (n == 2) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         if (n == 2) begin
            nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL midreset_ready got %b want 0001", req_ready); end
         end
         if (n == 5) begin
            nvec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd6) begin
               nerr++; $display("FAIL midreset_rsp got v=%0b id=%0d d=%0d want v=1 id=0 d=6", rsp_valid, rsp_id, rsp_data); end
         end else if (n >= 1) begin
            nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL midreset_rsp_idle cycle %0d got %0b want 0", n, rsp_valid); end
         end
         next_cycle();
      end
      reset = 1'b0;
   endtask

   task automatic test_reset_in_drain();
      do_reset();
      set_op(1, 8'd4, 8'd4, 8'd4);
      for (int n = 0; n <= 6; n++) begin
         flush     = (n == 1);
         reset     = (n == 2);
         req_valid = (n == 0) ? 4'b0010 : (n == 3) ? 4'b1111 : 4'b0000;
         set_op(0, 8'd5, 8'd1, 8'd0);
         @(negedge clk);
         if (n == 3) begin
            nvec++; if (req_ready !== 4'b0001 || halted !== 1'b0) begin
               nerr++; $display("FAIL drainreset_ready got rdy=%b h=%0b want rdy=0001 h=0", req_ready, halted); end
         end
         if (n == 6) begin
            nvec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd5) begin
               nerr++; $display("FAIL drainreset_rsp got v=%0b id=%0d d=%0d want v=1 id=0 d=5", rsp_valid, rsp_id, rsp_data); end
         end else if (n >= 3) begin
            nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL drainreset_rsp_idle cycle %0d got %0b want 0", n, rsp_valid); end
         end
         next_cycle();
      end
      reset = 1'b0;
   endtask

`ifdef MAC_SHARE_ARBITER_STATS_EN
   task automatic test_stats();
      do_reset();
      req_valid = 4'b0001;
      repeat (10) next_cycle();
      req_valid = '0;
      @(negedge clk);
      nvec++; if (stat_issued !== 16'd10) begin nerr++; $display("FAIL stat_ten got %0d want 10", stat_issued); end
      next_cycle();
      flush = 1'b1;
      repeat (6) next_cycle();
      flush = 1'b0;
      next_cycle();
      @(negedge clk);
      nvec++; if (stat_issued !== 16'd10) begin nerr++; $display("FAIL stat_flush got %0d want 10", stat_issued); end
      next_cycle();
      req_valid = 4'b1111;
      repeat (65536) next_cycle();
      req_valid = '0;
      @(negedge clk);
      nvec++; if (stat_issued !== 16'hFFFF) begin nerr++; $display("FAIL stat_sat got %h want ffff", stat_issued); end
      next_cycle();
      do_reset();
      @(negedge clk);
      nvec++; if (stat_issued !== 16'd0) begin nerr++; $display("FAIL stat_reset got %0d want 0", stat_issued); end
      next_cycle();
   endtask
`endif

   initial begin
      reset = 1'b1; flush = 1'b0; req_valid = '0;
      req_a = '0; req_b = '0; req_c = '0;
      test_reset();
      test_single_op();
      test_contention();
      test_max_values();
      test_single_hold();
      test_flush_inflight();
      test_flush_pulse();
      test_reset_mid_flight();
      test_reset_in_drain();
`ifdef MAC_SHARE_ARBITER_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
